alu_ex_stage: RTL and testbench
===============================

Name: alu_ex_stage

Overview:
- Execute pipeline stage that wraps one ALU #(N) instance between a valid/ready input from decode/register-read and a valid/ready output toward writeback.
- Applies one-deep result forwarding on operands.
- Registers the ALU result, FlagZ and destination tag.
- A 2-entry elastic buffer (output register plus skid register) keeps in_ready registered and sustains full throughput under backpressure.

Parameters:
N, 32, datapath width passed to ALU.
RW, 5, register tag width for rd/rs1/rs2.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream transaction present
in_ready  output  1  stage can accept this cycle
in_a  input  N  register-file operand A
in_b  input  N  register-file operand B
in_rs1  input  RW  source tag of A
in_rs2  input  RW  source tag of B
in_alufn  input  5  ALU function {subtract,bool1,bool0,shft,math}
in_rd  input  RW  destination tag
in_we  input  1  transaction writes rd
out_valid  output  1  result register holds a transaction
out_ready  input  1  downstream accepts this cycle
out_r  output  N  ALU result
out_z  output  1  FlagZ of out_r
out_rd  output  RW  destination tag
out_we  output  1  write enable

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, in_ready=1, out_r=0, out_z=0, out_rd=0, out_we=0.
  - Skid register empty.
  - Forward register invalid (fwd_v=0).
  - Reset mid-operation discards all held transactions. No partial output after release.
- Accept: acc = in_valid & in_ready. Drain: drn = out_valid & out_ready.
- Forwarding:
  - Forward register {fwd_v, fwd_rd, fwd_r} is loaded on every acc with {in_we & (in_rd!=0), in_rd, alu_R}.
  - It is independent of drain: it holds the youngest accepted result even after that result leaves the stage.
  - opA = fwd_r if fwd_v & (in_rs1==fwd_rd), else in_a. opB likewise with in_rs2.
  - Tag 0 never forwards.
- ALU: purely combinational on (opA, opB, in_alufn). alu_R and FlagZ are captured only on acc.
  - Compare ops (shft=1, math=1) yield 0 or 1, zero-extended.
- Latency: a transaction accepted at edge k appears on out_* after edge k when the output register is free; otherwise it appears after the edge following the drain of the older entry. In-order always.
- Buffer states:
  - EMPTY: out_valid=0, skid empty, in_ready=1.
    - acc -> ONE; result loaded into the output register.
  - ONE: out_valid=1, skid empty, in_ready=1.
    - acc & drn: stay ONE; new result loaded into the output register.
    - acc & ~drn: -> TWO; new result loaded into skid.
    - ~acc & drn: -> EMPTY.
    - ~acc & ~drn: hold.
  - TWO: out_valid=1, skid full, in_ready=0, so acc impossible.
    - drn: skid moves to the output register -> ONE.
    - ~drn: hold.
- in_ready is a register output: in_ready = (state != TWO). It must not combinationally depend on out_ready.
- While out_valid=1 & ~out_ready, all out_* are stable.
- in_* are ignored when acc=0, including forwarding-register updates.
- Throughput: 1 transaction/cycle whenever out_ready is held high.

Test Plan:
- Reset mid-flight: fill to TWO, pulse rst_n low between edges -> out_valid=0 and in_ready=1 immediately, with no clock edge needed; fwd_v=0, so the next op with rs1=fwd tag uses in_a.
- Add with out_ready=1: a=5, b=7, alufn=add, rd=3 -> next cycle out_r=12, out_z=0, out_rd=3, out_we=1, out_valid=1.
- Subtract to zero plus compare: a=9, b=9, subtract -> out_r=0, out_z=1. Then signed less-than, a=0xFFFFFFFF, b=1 -> out_r=1.
- Back-to-back forwarding:
  - op1 add rd=4 -> 10.
  - op2 rs1=4, in_a=0 (stale), b=1, add -> out_r=11.
  - Same sequence with rd=0 -> op2 out_r=1 (no forward).
- Backpressure: hold out_ready=0, issue 3 ops (results 1,2,3) -> in_ready=0 after 2 accepted and op3 stalls. Release out_ready -> outputs 1,2,3 in order, one per cycle, none lost or duplicated.
- Streaming with random out_ready toggling over 1000 ops against a reference model -> results match in order; in_ready never low in EMPTY/ONE; out_* stable while stalled.

Source files
------------

// File: rtl/alu_ex_stage.sv
// rtl/alu_ex_stage.sv - execute stage: operand forwarding, ALU, 2-entry elastic result buffer
// alufn = {subtract,bool1,bool0,shft,math}; bool0 selects right shift, bool1 arithmetic shift.
module alu_ex_stage #(
  parameter int N  = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  input  logic [RW-1:0] in_rs1,
  input  logic [RW-1:0] in_rs2,
  input  logic [4:0]    in_alufn,
  input  logic [RW-1:0] in_rd,
  input  logic          in_we,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_r,
  output logic          out_z,
  output logic [RW-1:0] out_rd,
  output logic          out_we
);
  localparam int SW = $clog2(N);

  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} state_t;

  state_t        state_q, state_d;
  logic          in_ready_q;
  logic          acc, drn;
  logic          load_out_new, load_out_skid, load_skid;

  logic          fwd_v_q;
  logic [RW-1:0] fwd_rd_q;
  logic [N-1:0]  fwd_r_q;

  logic [N-1:0]  out_r_q, skid_r_q;
  logic          out_z_q, skid_z_q;
  logic [RW-1:0] out_rd_q, skid_rd_q;
  logic          out_we_q, skid_we_q;

  assign acc = in_valid & in_ready_q;
  assign drn = (state_q != S_EMPTY) & out_ready;

  logic [N-1:0] op_a, op_b;
  assign op_a = (fwd_v_q && (in_rs1 == fwd_rd_q)) ? fwd_r_q : in_a;
  assign op_b = (fwd_v_q && (in_rs2 == fwd_rd_q)) ? fwd_r_q : in_b;

  logic f_sub, f_bool1, f_bool0, f_shft, f_math;
  assign {f_sub, f_bool1, f_bool0, f_shft, f_math} = in_alufn;

  // Compares always subtract so the flags describe op_a - op_b.
  logic          cmp_op, cin;
  logic [N-1:0]  b_x, sum;
  logic [N:0]    sum_w;
  logic          flag_c, flag_z, flag_n, flag_v, cmp_bit;
  assign cmp_op = f_shft & f_math;
  assign cin    = f_sub | cmp_op;
  assign b_x    = cin ? ~op_b : op_b;
  assign sum_w  = {1'b0, op_a} + {1'b0, b_x} + {{N{1'b0}}, cin};
  assign sum    = sum_w[N-1:0];
  assign flag_c = sum_w[N];
  assign flag_z = (sum == '0);
  assign flag_n = sum[N-1];
  assign flag_v = (op_a[N-1] & b_x[N-1] & ~sum[N-1]) | (~op_a[N-1] & ~b_x[N-1] & sum[N-1]);

  always_comb begin
    cmp_bit = 1'b0;
    case ({f_bool1, f_bool0})
      2'b00: cmp_bit = ~flag_c;
      2'b01: cmp_bit = flag_z;
      2'b10: cmp_bit = flag_n ^ flag_v;
      2'b11: cmp_bit = (flag_n ^ flag_v) | flag_z;
      default: cmp_bit = 1'b0;
    endcase
  end

  logic [SW-1:0] shamt;
  logic [N-1:0]  shl, shr, bool_r, alu_r;
  logic          alu_z;
  assign shamt = op_b[SW-1:0];
  assign shl   = op_a << shamt;
  assign shr   = f_bool1 ? $unsigned($signed(op_a) >>> shamt) : (op_a >> shamt);

  always_comb begin
    bool_r = '0;
    case ({f_bool1, f_bool0})
      2'b00: bool_r = op_a & op_b;
      2'b01: bool_r = op_a | op_b;
      2'b10: bool_r = op_a ^ op_b;
      2'b11: bool_r = op_a;
      default: bool_r = '0;
    endcase
  end

  always_comb begin
    alu_r = '0;
    if (cmp_op)      alu_r = {{(N-1){1'b0}}, cmp_bit};
    else if (f_shft) alu_r = f_bool0 ? shr : shl;
    else if (f_math) alu_r = sum;
    else             alu_r = bool_r;
  end
  assign alu_z = (alu_r == '0);

  always_comb begin
    state_d       = state_q;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state_q)
      S_EMPTY: if (acc) begin
        state_d      = S_ONE;
        load_out_new = 1'b1;
      end
      S_ONE: begin
        if (acc && drn) begin
          load_out_new = 1'b1;
        end else if (acc) begin
          state_d   = S_TWO;
          load_skid = 1'b1;
        end else if (drn) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: if (drn) begin
        state_d       = S_ONE;
        load_out_skid = 1'b1;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // in_ready is registered from the next state so it never sees out_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != S_TWO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r_q   <= '0;
      out_z_q   <= 1'b0;
      out_rd_q  <= '0;
      out_we_q  <= 1'b0;
      skid_r_q  <= '0;
      skid_z_q  <= 1'b0;
      skid_rd_q <= '0;
      skid_we_q <= 1'b0;
      fwd_v_q   <= 1'b0;
      fwd_rd_q  <= '0;
      fwd_r_q   <= '0;
    end else begin
      if (load_out_new) begin
        out_r_q  <= alu_r;
        out_z_q  <= alu_z;
        out_rd_q <= in_rd;
        out_we_q <= in_we;
      end else if (load_out_skid) begin
        out_r_q  <= skid_r_q;
        out_z_q  <= skid_z_q;
        out_rd_q <= skid_rd_q;
        out_we_q <= skid_we_q;
      end
      if (load_skid) begin
        skid_r_q  <= alu_r;
        skid_z_q  <= alu_z;
        skid_rd_q <= in_rd;
        skid_we_q <= in_we;
      end
      if (acc) begin
        fwd_v_q  <= in_we & (in_rd != '0);
        fwd_rd_q <= in_rd;
        fwd_r_q  <= alu_r;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != S_EMPTY);
  assign out_r     = out_r_q;
  assign out_z     = out_z_q;
  assign out_rd    = out_rd_q;
  assign out_we    = out_we_q;

endmodule

// File: tb/tb_alu_ex_stage.sv
// tb/tb_alu_ex_stage.sv - self-checking bench for alu_ex_stage
module tb_alu_ex_stage;
  localparam logic [4:0] OP_AND = 5'b00000, OP_OR  = 5'b00100, OP_XOR = 5'b01000, OP_A   = 5'b01100;
  localparam logic [4:0] OP_ADD = 5'b00001, OP_SUB = 5'b10001;
  localparam logic [4:0] OP_SLL = 5'b00010, OP_SRL = 5'b00110, OP_SRA = 5'b01110;
  localparam logic [4:0] OP_LTU = 5'b10011, OP_EQ  = 5'b10111, OP_LT  = 5'b11011, OP_LE = 5'b11111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic [4:0]  in_rs1, in_rs2, in_alufn, in_rd;
  logic        in_we;
  logic        out_valid, out_ready;
  logic [31:0] out_r;
  logic        out_z;
  logic [4:0]  out_rd;
  logic        out_we;

  int total = 0;
  int bad = 0;

  alu_ex_stage #(.N(32), .RW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_alufn(in_alufn), .in_rd(in_rd), .in_we(in_we),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_z(out_z), .out_rd(out_rd), .out_we(out_we)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] r; logic z; logic [4:0] rd; logic we; } exp_t;
  exp_t expq[$];

  logic [4:0] op_table [13] = '{OP_AND, OP_OR, OP_XOR, OP_A, OP_ADD, OP_SUB, OP_SLL,
                                OP_SRL, OP_SRA, OP_LTU, OP_EQ, OP_LT, OP_LE};

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] fn);
    case (fn)
      OP_AND: return a & b;
      OP_OR:  return a | b;
      OP_XOR: return a ^ b;
      OP_A:   return a;
      OP_ADD: return a + b;
      OP_SUB: return a - b;
      OP_SLL: return a << b[4:0];
      OP_SRL: return a >> b[4:0];
      OP_SRA: return $unsigned($signed(a) >>> b[4:0]);
      OP_LTU: return (a < b) ? 32'd1 : 32'd0;
      OP_EQ:  return (a == b) ? 32'd1 : 32'd0;
      OP_LT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_LE:  return ($signed(a) <= $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rs1,
                        input logic [4:0] fn, input logic [4:0] rd, input logic we);
    in_valid = 1'b1; in_a = a; in_b = b; in_rs1 = rs1; in_rs2 = 5'd0;
    in_alufn = fn; in_rd = rd; in_we = we;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_rs1 = '0; in_rs2 = '0; in_alufn = '0; in_rd = '0; in_we = 1'b0;
    #12;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if ({out_r, out_z, out_rd, out_we} !== 39'd0)
      begin bad++; $display("FAIL reset_outs got r=%h z=%b rd=%0d we=%b want all 0", out_r, out_z, out_rd, out_we); end
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    set_op(32'd5, 32'd7, 5'd0, OP_ADD, 5'd3, 1'b1);
    step();
    in_valid = 1'b0;
    total++; if ({out_valid, out_r, out_z, out_rd, out_we} !== {1'b1, 32'd12, 1'b0, 5'd3, 1'b1})
      begin bad++; $display("FAIL add got v=%b r=%0d z=%b rd=%0d we=%b want v=1 r=12 z=0 rd=3 we=1",
                             out_valid, out_r, out_z, out_rd, out_we); end
    step();
  endtask

  task automatic test_sub_cmp();
    set_op(32'd9, 32'd9, 5'd0, OP_SUB, 5'd2, 1'b1);
    step();
    total++; if ({out_r, out_z} !== {32'd0, 1'b1})
      begin bad++; $display("FAIL sub_zero got r=%0d z=%b want r=0 z=1", out_r, out_z); end
    set_op(32'hFFFF_FFFF, 32'd1, 5'd0, OP_LT, 5'd2, 1'b1);
    step();
    in_valid = 1'b0;
    total++; if ({out_r, out_z} !== {32'd1, 1'b0})
      begin bad++; $display("FAIL slt got r=%0d z=%b want r=1 z=0", out_r, out_z); end
    step();
  endtask

  task automatic test_back_to_back();
    set_op(32'd3, 32'd7, 5'd0, OP_ADD, 5'd4, 1'b1);
    step();
    total++; if (out_r !== 32'd10) begin bad++; $display("FAIL fwd_op1 got=%0d want=10", out_r); end
    set_op(32'd0, 32'd1, 5'd4, OP_ADD, 5'd5, 1'b1);
    step();
    total++; if (out_r !== 32'd11) begin bad++; $display("FAIL fwd_op2 got=%0d want=11", out_r); end
    set_op(32'd3, 32'd7, 5'd0, OP_ADD, 5'd0, 1'b1);
    step();
    total++; if (out_r !== 32'd10) begin bad++; $display("FAIL nofwd_op1 got=%0d want=10", out_r); end
    set_op(32'd0, 32'd1, 5'd0, OP_ADD, 5'd6, 1'b1);
    step();
    in_valid = 1'b0;
    total++; if (out_r !== 32'd1) begin bad++; $display("FAIL nofwd_op2 got=%0d want=1", out_r); end
    step();
  endtask

  task automatic test_backpressure();
    logic [31:0] got[$];
    int cyc[$];
    logic pend;
    out_ready = 1'b0;
    set_op(32'd1, 32'd0, 5'd0, OP_ADD, 5'd1, 1'b1);
    step();
    set_op(32'd2, 32'd0, 5'd0, OP_ADD, 5'd2, 1'b1);
    step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b want=0", in_ready); end
    set_op(32'd3, 32'd0, 5'd0, OP_ADD, 5'd3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if ({in_ready, out_valid, out_r} !== {1'b0, 1'b1, 32'd1})
        begin bad++; $display("FAIL bp_stall got ready=%b v=%b r=%0d want ready=0 v=1 r=1", in_ready, out_valid, out_r); end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (out_valid) begin got.push_back(out_r); cyc.push_back(c); end
      pend = in_valid && in_ready;
      step();
      if (pend) in_valid = 1'b0;
    end
    total++; if (got.size() !== 3) begin bad++; $display("FAIL bp_count got=%0d want=3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      total++; if (got[i] !== 32'(i + 1) || cyc[i] !== cyc[0] + i)
        begin bad++; $display("FAIL bp_order idx=%0d got r=%0d cyc=%0d want r=%0d cyc=%0d", i, got[i], cyc[i], i + 1, cyc[0] + i); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    set_op(32'd20, 32'd0, 5'd0, OP_ADD, 5'd6, 1'b1);
    step();
    set_op(32'd21, 32'd0, 5'd0, OP_ADD, 5'd6, 1'b1);
    step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++; if ({out_valid, in_ready, out_r} !== {1'b0, 1'b1, 32'd0})
      begin bad++; $display("FAIL midrst got v=%b ready=%b r=%0d want v=0 ready=1 r=0", out_valid, in_ready, out_r); end
    #1 rst_n = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_residue got v=%b want=0", out_valid); end
    out_ready = 1'b1;
    set_op(32'd100, 32'd1, 5'd6, OP_ADD, 5'd7, 1'b1);
    step();
    in_valid = 1'b0;
    total++; if (out_r !== 32'd101) begin bad++; $display("FAIL midrst_nofwd got=%0d want=101", out_r); end
    step();
  endtask

  task automatic test_stream();
    logic        mfv = 1'b0;
    logic [4:0]  mfrd = '0;
    logic [31:0] mfr = '0;
    logic        have_op = 1'b0;
    logic        prev_stall = 1'b0;
    logic [38:0] prev_out = '0;
    int accepted = 0, drained = 0, cycles = 0;
    exp_t e;
    logic [31:0] oa, ob;
    while (drained < 1000) begin
      if (cycles > 20000) begin
        bad++; total++;
        $display("FAIL stream_timeout got drained=%0d want=1000", drained);
        break;
      end
      cycles++;
      total++; if (out_valid !== (expq.size() != 0))
        begin bad++; $display("FAIL stream_valid got=%b want=%b", out_valid, expq.size() != 0); end
      total++; if (in_ready !== (expq.size() < 2))
        begin bad++; $display("FAIL stream_ready got=%b want=%b", in_ready, expq.size() < 2); end
      if (prev_stall) begin
        total++; if ({out_r, out_z, out_rd, out_we} !== prev_out)
          begin bad++; $display("FAIL stream_stable got=%h want=%h", {out_r, out_z, out_rd, out_we}, prev_out); end
      end
      out_ready = ($urandom % 3) != 0;
      if (out_valid && out_ready && expq.size() != 0) begin
        e = expq.pop_front();
        total++; if ({out_r, out_z, out_rd, out_we} !== {e.r, e.z, e.rd, e.we})
          begin bad++; $display("FAIL stream_data n=%0d got r=%h z=%b rd=%0d we=%b want r=%h z=%b rd=%0d we=%b",
                                drained, out_r, out_z, out_rd, out_we, e.r, e.z, e.rd, e.we); end
        drained++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out = {out_r, out_z, out_rd, out_we};
      if (!have_op && accepted < 1000 && ($urandom % 4) != 0) begin
        have_op = 1'b1;
        in_a = ($urandom % 4 == 0) ? 32'($urandom % 8) : $urandom;
        in_b = ($urandom % 8 == 0) ? in_a : (($urandom % 2 == 0) ? 32'($urandom % 40) : $urandom);
        in_rs1 = 5'($urandom_range(0, 3));
        in_rs2 = 5'($urandom_range(0, 3));
        in_rd = 5'($urandom_range(0, 3));
        in_we = ($urandom % 4) != 0;
        in_alufn = op_table[$urandom_range(0, 12)];
      end
      if (have_op) begin
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
        in_a = $urandom; in_b = $urandom; in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
        in_rd = 5'($urandom); in_we = 1'($urandom); in_alufn = 5'($urandom);
      end
      if (in_valid && in_ready) begin
        oa = (mfv && in_rs1 == mfrd) ? mfr : in_a;
        ob = (mfv && in_rs2 == mfrd) ? mfr : in_b;
        e.r = ref_alu(oa, ob, in_alufn);
        e.z = (e.r == 32'd0);
        e.rd = in_rd;
        e.we = in_we;
        expq.push_back(e);
        mfv = in_we && (in_rd != 5'd0);
        mfrd = in_rd;
        mfr = e.r;
        have_op = 1'b0;
        accepted++;
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_cmp();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    test_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
